// File: rtl/ghash_agg_engine.sv
// LANES-way aggregated GHASH engine: folds 128-bit blocks into Y using H^1..H^LANES.
// Optional macro GHASH_LEN_BLOCK_EN folds the {len_a, len_c} length block before done.
module ghash_agg_engine #(
  parameter int unsigned LANES   = 4,
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_W-1:0]     num_blocks,
  input  logic [LANES*128-1:0] h_pow,
  input  logic                 h_valid,
  input  logic [LANES*128-1:0] blk_data,
  input  logic                 blk_valid,
  output logic                 blk_ready,
  output logic                 busy,
  output logic [127:0]         ghash_o,
  output logic                 done,
  output logic                 error_o
`ifdef GHASH_LEN_BLOCK_EN
  ,
  input  logic [63:0]          len_a,
  input  logic [63:0]          len_c
`endif
);

  typedef enum logic [2:0] {StIdle, StAccept, StMul, StFinal, StDone} state_e;

  localparam int unsigned MCW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam int unsigned KW  = $clog2(LANES + 1);
  localparam logic [127:0] RPoly = {8'he1, 120'd0};

  // Bit 127 is the coefficient of x^0, so shifting right multiplies by x.
  function automatic logic [127:0] gf_mul(input logic [127:0] x, input logic [127:0] y);
    logic [127:0] z;
    logic [127:0] v;
    z = '0;
    v = y;
    for (int i = 127; i >= 0; i--) begin
      if (x[i]) z = z ^ v;
      v = v[0] ? ((v >> 1) ^ RPoly) : (v >> 1);
    end
    return z;
  endfunction

  state_e             state_q, state_d;
  logic [127:0]       y_q;
  logic [127:0]       ghash_q;
  logic [CNT_W-1:0]   rem_q;
  logic [KW-1:0]      k_q;
  logic [MCW-1:0]     mul_cnt_q;
  logic [127:0]       pipe_q [MUL_LAT];
  logic               busy_q, done_q, err_q;
`ifdef GHASH_LEN_BLOCK_EN
  logic [127:0]       len_q;
  logic               len_phase_q;
`endif

  logic [CNT_W-1:0]     grp_k_full;
  logic [KW-1:0]        grp_k;
  logic [KW-1:0]        fold_k;
  logic [LANES*128-1:0] fold_x;
  logic [127:0]         fold_y;
  logic [CNT_W-1:0]     rem_next;
  logic                 mul_last;
  logic                 load;

  assign grp_k_full = (rem_q < CNT_W'(LANES)) ? rem_q : CNT_W'(LANES);
  assign grp_k      = KW'(grp_k_full);
  assign rem_next   = rem_q - CNT_W'(k_q);
  assign mul_last   = (mul_cnt_q == MCW'(MUL_LAT - 1));

  // Aggregated fold: lane j of a k-block group is multiplied by H^(k-j).
  always_comb begin
    logic [127:0] xin;
    logic [127:0] hsel;
    int           pidx;
    fold_x = blk_data;
    fold_k = grp_k;
    load   = (state_q == StAccept) && blk_valid;
`ifdef GHASH_LEN_BLOCK_EN
    if (state_q == StFinal) begin
      fold_x          = '0;
      fold_x[127:0]   = len_q;
      fold_k          = KW'(1);
      load            = !len_phase_q;
    end
`endif
    fold_y = '0;
    for (int j = 0; j < int'(LANES); j++) begin
      xin  = fold_x[128*j +: 128];
      if (j == 0) xin = xin ^ y_q;
      pidx = int'(fold_k) - 1 - j;
      hsel = '0;
      for (int p = 0; p < int'(LANES); p++) begin
        if (p == pidx) hsel = h_pow[128*p +: 128];
      end
      if (j < int'(fold_k)) fold_y = fold_y ^ gf_mul(xin, hsel);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start && h_valid && (num_blocks != '0)) state_d = StAccept;
      StAccept: if (blk_valid) state_d = StMul;
      StMul:    if (mul_last) state_d = (rem_next == '0) ? StFinal : StAccept;
`ifdef GHASH_LEN_BLOCK_EN
      StFinal:  state_d = len_phase_q ? StDone : StMul;
`else
      StFinal:  state_d = StDone;
`endif
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      y_q       <= '0;
      ghash_q   <= '0;
      rem_q     <= '0;
      k_q       <= '0;
      mul_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      for (int i = 0; i < int'(MUL_LAT); i++) pipe_q[i] <= '0;
`ifdef GHASH_LEN_BLOCK_EN
      len_q       <= '0;
      len_phase_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      if (load) pipe_q[0] <= fold_y;
      for (int i = 1; i < int'(MUL_LAT); i++) pipe_q[i] <= pipe_q[i-1];
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (h_valid && (num_blocks != '0)) begin
              y_q    <= '0;
              rem_q  <= num_blocks;
              busy_q <= 1'b1;
`ifdef GHASH_LEN_BLOCK_EN
              len_q       <= {len_a, len_c};
              len_phase_q <= 1'b0;
`endif
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        StAccept: begin
          if (blk_valid) begin
            k_q       <= grp_k;
            mul_cnt_q <= '0;
          end
        end
        StMul: begin
          mul_cnt_q <= mul_cnt_q + MCW'(1);
          if (mul_last) begin
            y_q   <= pipe_q[MUL_LAT-1];
            rem_q <= rem_next;
          end
        end
        StFinal: begin
`ifdef GHASH_LEN_BLOCK_EN
          if (!len_phase_q) begin
            // Length block rides the MUL path as a k=1 group that consumes no blocks.
            len_phase_q <= 1'b1;
            k_q         <= '0;
            mul_cnt_q   <= '0;
          end else begin
            ghash_q <= y_q;
            done_q  <= 1'b1;
          end
`else
          ghash_q <= y_q;
          done_q  <= 1'b1;
`endif
        end
        StDone:  busy_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign blk_ready = (state_q == StAccept) && !rst;
  assign busy      = busy_q;
  assign ghash_o   = ghash_q;
  assign done      = done_q;
  assign error_o   = err_q;

endmodule
